// File: rtl/irq_pad_ctrl.sv
// irq_pad_ctrl: interrupt controller between the IRQ/EOI GPIO pads and the SOC core.
// Synchronises raw pad levels, tracks pending/in-service state per channel, presents
// the lowest eligible id over a valid/ready port and drives fixed-width EOI pulses.
module irq_pad_ctrl #(
  parameter int unsigned N_IRQ       = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EOI_PULSE   = 4,
  parameter int unsigned ID_W        = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq_pad_in,
  output logic [N_IRQ-1:0] eoi_pad_out,
  input  logic [N_IRQ-1:0] cfg_edge,
  input  logic [N_IRQ-1:0] cfg_mask,
  output logic             irq_valid,
  output logic [ID_W-1:0]  irq_id,
  input  logic             irq_ready,
  input  logic             eoi_valid,
  input  logic [ID_W-1:0]  eoi_id,
  output logic             eoi_ready,
  output logic [N_IRQ-1:0] pending
);

  // Counter holds EOI_PULSE-1 down to 0.
  localparam int unsigned CNT_W = (EOI_PULSE > 1) ? $clog2(EOI_PULSE) : 1;

  localparam logic [0:0] PRES_IDLE = 1'b0;
  localparam logic [0:0] PRES_BUSY = 1'b1;
  localparam logic [0:0] EOI_IDLE  = 1'b0;
  localparam logic [0:0] EOI_PULSE_ST = 1'b1;

  // Decode a channel id into a one-hot vector; out-of-range ids decode to zero.
  function automatic logic [N_IRQ-1:0] id_to_vec(input logic [ID_W-1:0] id);
    logic [N_IRQ-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < N_IRQ; i++) begin
      if (id == ID_W'(i)) v[i] = 1'b1;
    end
    return v;
  endfunction

  logic [N_IRQ-1:0] sync_q [SYNC_STAGES];
  logic [N_IRQ-1:0] s;
  logic [N_IRQ-1:0] s_prev_q;
  logic [N_IRQ-1:0] rise;

  logic [N_IRQ-1:0] pending_q, pending_d;
  logic [N_IRQ-1:0] in_service_q, in_service_d;
  logic [N_IRQ-1:0] eligible;
  logic             any_eligible;
  logic [ID_W-1:0]  low_id;

  logic [0:0]       pres_state_q, pres_state_d;
  logic [ID_W-1:0]  irq_id_q, irq_id_d;
  logic             irq_hs;
  logic [N_IRQ-1:0] irq_vec;

  logic [0:0]       eoi_state_q, eoi_state_d;
  logic [ID_W-1:0]  eoi_sel_q, eoi_sel_d;
  logic [CNT_W-1:0] eoi_cnt_q, eoi_cnt_d;
  logic [N_IRQ-1:0] eoi_pad_q, eoi_pad_d;
  logic [N_IRQ-1:0] eoi_vec;
  logic             eoi_hit;

  // Pad synchroniser chain plus one cycle of history for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      s_prev_q <= '0;
    end else begin
      sync_q[0] <= irq_pad_in;
      for (int unsigned k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      s_prev_q <= s;
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_prev_q;

  assign irq_valid = (pres_state_q == PRES_BUSY);
  assign irq_id    = irq_id_q;
  assign eoi_ready = (eoi_state_q == EOI_IDLE);
  assign eoi_pad_out = eoi_pad_q;
  assign pending   = pending_q;

  assign irq_hs   = irq_valid & irq_ready;
  assign irq_vec  = irq_hs ? id_to_vec(irq_id_q) : '0;
  assign eoi_vec  = id_to_vec(eoi_id);
  // EOI for a channel not in service is accepted but has no effect.
  assign eoi_hit  = eoi_valid & eoi_ready & (|(eoi_vec & in_service_q));
  assign eligible = pending_q & cfg_mask & ~in_service_q;

  // Lowest-numbered eligible channel.
  always_comb begin
    low_id       = '0;
    any_eligible = |eligible;
    for (int i = int'(N_IRQ) - 1; i >= 0; i--) begin
      if (eligible[i]) low_id = ID_W'(i);
    end
  end

  // Pending and in-service next state; a new set wins over a same-cycle clear.
  always_comb begin
    pending_d = pending_q & ~irq_vec;
    // Level channels do not re-pend in the cycle they are accepted.
    pending_d = pending_d | (rise & cfg_edge) | (s & ~cfg_edge & ~in_service_q & ~irq_vec);
    in_service_d = in_service_q;
    if (eoi_hit) in_service_d = in_service_d & ~eoi_vec;
    in_service_d = in_service_d | irq_vec;
  end

  // Presentation FSM: latch an id and hold it stable until the handshake.
  always_comb begin
    pres_state_d = pres_state_q;
    irq_id_d     = irq_id_q;
    case (pres_state_q)
      PRES_IDLE: begin
        if (any_eligible) begin
          pres_state_d = PRES_BUSY;
          irq_id_d     = low_id;
        end
      end
      PRES_BUSY: begin
        if (irq_hs) pres_state_d = PRES_IDLE;
      end
      default: pres_state_d = PRES_IDLE;
    endcase
  end

  // EOI FSM: one pulse of EOI_PULSE cycles on the completed channel's pad.
  always_comb begin
    eoi_state_d = eoi_state_q;
    eoi_sel_d   = eoi_sel_q;
    eoi_cnt_d   = eoi_cnt_q;
    case (eoi_state_q)
      EOI_IDLE: begin
        if (eoi_hit) begin
          eoi_state_d = EOI_PULSE_ST;
          eoi_sel_d   = eoi_id;
          eoi_cnt_d   = CNT_W'(EOI_PULSE - 1);
        end
      end
      EOI_PULSE_ST: begin
        if (eoi_cnt_q == '0) eoi_state_d = EOI_IDLE;
        else                 eoi_cnt_d   = eoi_cnt_q - CNT_W'(1);
      end
      default: eoi_state_d = EOI_IDLE;
    endcase
    // Pad drive is registered so the pads never see decode glitches.
    eoi_pad_d = (eoi_state_d == EOI_PULSE_ST) ? id_to_vec(eoi_sel_d) : '0;
  end

  // Controller state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q    <= '0;
      in_service_q <= '0;
      pres_state_q <= PRES_IDLE;
      irq_id_q     <= '0;
      eoi_state_q  <= EOI_IDLE;
      eoi_sel_q    <= '0;
      eoi_cnt_q    <= '0;
      eoi_pad_q    <= '0;
    end else begin
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      pres_state_q <= pres_state_d;
      irq_id_q     <= irq_id_d;
      eoi_state_q  <= eoi_state_d;
      eoi_sel_q    <= eoi_sel_d;
      eoi_cnt_q    <= eoi_cnt_d;
      eoi_pad_q    <= eoi_pad_d;
    end
  end

endmodule

// File: tb/tb_irq_pad_ctrl.sv
// Testbench for irq_pad_ctrl: directed scenarios plus randomized edge bursts, with a
// scoreboard of expected irq ids and expected EOI pulses checked by monitor processes.
module tb_irq_pad_ctrl;

  localparam int N     = 16;
  localparam int SYNC  = 2;
  localparam int PULSE = 4;
  localparam int IDW   = 4;

  logic           clk;
  logic           rst;
  logic [N-1:0]   irq_pad_in;
  logic [N-1:0]   eoi_pad_out;
  logic [N-1:0]   cfg_edge;
  logic [N-1:0]   cfg_mask;
  logic           irq_valid;
  logic [IDW-1:0] irq_id;
  logic           irq_ready;
  logic           eoi_valid;
  logic [IDW-1:0] eoi_id;
  logic           eoi_ready;
  logic [N-1:0]   pending;

  int n_checks = 0;
  int n_errors = 0;
  int acc_cnt  = 0;
  int exp_irq[$];
  int exp_eoi[$];

  irq_pad_ctrl #(
    .N_IRQ      (N),
    .SYNC_STAGES(SYNC),
    .EOI_PULSE  (PULSE),
    .ID_W       (IDW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .irq_pad_in (irq_pad_in),
    .eoi_pad_out(eoi_pad_out),
    .cfg_edge   (cfg_edge),
    .cfg_mask   (cfg_mask),
    .irq_valid  (irq_valid),
    .irq_id     (irq_id),
    .irq_ready  (irq_ready),
    .eoi_valid  (eoi_valid),
    .eoi_id     (eoi_id),
    .eoi_ready  (eoi_ready),
    .pending    (pending)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, expected completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  // Called at posedge+1; returns at posedge+1 with irq_valid seen, or reports timeout.
  task automatic wait_valid(input string name);
    for (int t = 0; t < 20; t++) begin
      if (irq_valid) break;
      @(posedge clk); #1;
    end
    if (!irq_valid) fail_now(name);
  endtask

  task automatic eoi_issue(input int id, input bit expect_pulse);
    int t;
    t = 0;
    while (!eoi_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (!eoi_ready) fail_now("eoi_ready_wait");
    if (expect_pulse) exp_eoi.push_back(id);
    eoi_valid = 1'b1;
    eoi_id    = IDW'(id);
    @(posedge clk); #1;
    eoi_valid = 1'b0;
  endtask

  task automatic wait_accepts(input int target);
    for (int t = 0; t < 300; t++) begin
      if (acc_cnt >= target) break;
      @(posedge clk); #1;
      irq_ready = 1'($urandom_range(0, 1));
    end
    if (acc_cnt < target) fail_now("accept_wait");
    irq_ready = 1'b0;
  endtask

  // Irq monitor: pop the scoreboard on every handshake, and check hold-while-stalled.
  initial begin
    bit          prev_stall;
    logic [IDW-1:0] prev_id;
    int          e;
    prev_stall = 0;
    prev_id    = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 0;
      end else begin
        if (prev_stall) begin
          check("irq_valid_held", 64'(irq_valid), 64'd1);
          check("irq_id_held", 64'(irq_id), 64'(prev_id));
        end
        if (irq_valid && irq_ready) begin
          if (exp_irq.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_irq: got id %0d expected none", irq_id);
          end else begin
            e = exp_irq.pop_front();
            check("irq_id_order", 64'(irq_id), 64'(e));
          end
          acc_cnt++;
        end
        prev_stall = irq_valid && !irq_ready;
        prev_id    = irq_id;
      end
    end
  end

  // EOI monitor: measure each pad pulse and match it against the expected queue.
  initial begin
    bit          in_pulse;
    int          run_len;
    logic [N-1:0] run_vec;
    logic [N-1:0] ev;
    int          e;
    in_pulse = 0;
    run_len  = 0;
    run_vec  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (in_pulse) begin
          if (exp_eoi.size() > 0) void'(exp_eoi.pop_front());
          in_pulse = 0;
        end
      end else if (eoi_pad_out != '0) begin
        check("eoi_onehot", 64'($onehot(eoi_pad_out)), 64'd1);
        check("eoi_ready_low", 64'(eoi_ready), 64'd0);
        if (!in_pulse) begin
          in_pulse = 1;
          run_len  = 1;
          run_vec  = eoi_pad_out;
        end else begin
          check("eoi_pulse_stable", 64'(eoi_pad_out), 64'(run_vec));
          run_len++;
        end
      end else if (in_pulse) begin
        in_pulse = 0;
        check("eoi_width", 64'(run_len), 64'(PULSE));
        check("eoi_ready_back", 64'(eoi_ready), 64'd1);
        if (exp_eoi.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_eoi_pulse: got pads 0x%0h expected none", run_vec);
        end else begin
          e = exp_eoi.pop_front();
          ev = '0;
          ev[e] = 1'b1;
          check("eoi_pad_id", 64'(run_vec), 64'(ev));
        end
      end
    end
  end

  initial begin
    logic [N-1:0] r_set, m_set, served, held;
    int ids[$];
    int cnt, a, b, tmp, bogus;

    rst        = 1'b1;
    irq_pad_in = '0;
    cfg_edge   = '1;
    cfg_mask   = '1;
    irq_ready  = 1'b0;
    eoi_valid  = 1'b0;
    eoi_id     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_eoi_pad", 64'(eoi_pad_out), 64'd0);
    check("rst_eoi_ready", 64'(eoi_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_irq_valid", 64'(irq_valid), 64'd0);
    check("rst_irq_id", 64'(irq_id), 64'd0);
    check("rst_pending", 64'(pending), 64'd0);
    @(posedge clk); #1;

    // Edge channel 5, one-cycle pulse: latency to pending and presentation.
    irq_pad_in = 16'h0020;
    @(posedge clk); #1;
    irq_pad_in = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("lat_pending_edge2", 64'(pending), 64'h0020);
    check("lat_valid_edge2", 64'(irq_valid), 64'd0);
    @(posedge clk); #1;
    check("lat_valid_edge3", 64'(irq_valid), 64'd1);
    check("lat_id_edge3", 64'(irq_id), 64'd5);
    exp_irq.push_back(5);
    irq_ready = 1'b1;
    @(posedge clk); #1;
    irq_ready = 1'b0;
    check("hs_pending_clear", 64'(pending), 64'd0);
    check("hs_valid_drop", 64'(irq_valid), 64'd0);
    eoi_issue(5, 1);

    // Channels 3 and 9 together: lowest first, next one a cycle after the handshake.
    irq_pad_in = 16'h0208;
    exp_irq.push_back(3);
    exp_irq.push_back(9);
    @(posedge clk); #1;
    irq_pad_in = '0;
    wait_valid("prio_wait");
    check("prio_first", 64'(irq_id), 64'd3);
    irq_ready = 1'b1;
    @(posedge clk); #1;
    check("prio_gap", 64'(irq_valid), 64'd0);
    @(posedge clk); #1;
    check("prio_second_valid", 64'(irq_valid), 64'd1);
    check("prio_second_id", 64'(irq_id), 64'd9);
    @(posedge clk); #1;
    irq_ready = 1'b0;

    // EOI 3 pulses; EOI 7 (never in service) is accepted without a pulse.
    eoi_issue(3, 1);
    eoi_issue(7, 0);
    check("eoi_not_in_service_ready", 64'(eoi_ready), 64'd1);
    repeat (PULSE + 3) @(posedge clk);
    #1;
    check("eoi_queue_drained", 64'(exp_eoi.size()), 64'd0);
    eoi_issue(9, 1);

    // Level channel 2: held high through EOI re-pends; low before EOI does not.
    cfg_edge = 16'hFFFB;
    irq_pad_in = 16'h0004;
    exp_irq.push_back(2);
    wait_valid("lvl_wait1");
    check("lvl_id1", 64'(irq_id), 64'd2);
    irq_ready = 1'b1;
    @(posedge clk); #1;
    irq_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("lvl_no_repend_in_service", 64'(pending), 64'd0);
    exp_irq.push_back(2);
    eoi_issue(2, 1);
    wait_valid("lvl_wait2");
    check("lvl_id2", 64'(irq_id), 64'd2);
    irq_ready = 1'b1;
    @(posedge clk); #1;
    irq_ready = 1'b0;
    irq_pad_in = '0;
    repeat (4) @(posedge clk);
    #1;
    eoi_issue(2, 1);
    repeat (12) @(posedge clk);
    #1;
    check("lvl_low_no_valid", 64'(irq_valid), 64'd0);
    check("lvl_low_no_pending", 64'(pending), 64'd0);
    cfg_edge = '1;

    // Edge channel 4 re-fires while in service: held pending, presented once after EOI.
    irq_pad_in = 16'h0010;
    exp_irq.push_back(4);
    @(posedge clk); #1;
    irq_pad_in = '0;
    wait_valid("ins_wait");
    irq_ready = 1'b1;
    @(posedge clk); #1;
    irq_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      irq_pad_in = 16'h0010;
      @(posedge clk); #1;
      irq_pad_in = '0;
      repeat (4) @(posedge clk);
      #1;
      check("ins_pending_held", 64'(pending), 64'h0010);
      check("ins_not_presented", 64'(irq_valid), 64'd0);
    end
    irq_ready = 1'b1;
    exp_irq.push_back(4);
    eoi_issue(4, 1);
    repeat (10) @(posedge clk);
    #1;
    irq_ready = 1'b0;
    check("ins_single_presentation", 64'(exp_irq.size()), 64'd0);
    check("ins_pending_clear", 64'(pending), 64'd0);
    eoi_issue(4, 1);

    // Channel 1 stalled, then masked: presentation holds. Then reset mid-pulse.
    irq_pad_in = 16'h0002;
    @(posedge clk); #1;
    irq_pad_in = '0;
    wait_valid("mask_wait");
    check("mask_id", 64'(irq_id), 64'd1);
    cfg_mask = 16'hFFFD;
    repeat (3) @(posedge clk);
    #1;
    check("mask_valid_kept", 64'(irq_valid), 64'd1);
    check("mask_id_kept", 64'(irq_id), 64'd1);
    cfg_mask = '1;
    exp_irq.push_back(1);
    irq_ready = 1'b1;
    @(posedge clk); #1;
    irq_ready = 1'b0;
    irq_pad_in = 16'h0040;
    eoi_issue(1, 1);
    irq_pad_in = '0;
    wait_valid("rstmid_wait");
    check("rstmid_pulse_active", 64'(eoi_pad_out), 64'h0002);
    rst = 1'b1;
    #1;
    check("rstmid_eoi_pad", 64'(eoi_pad_out), 64'd0);
    check("rstmid_eoi_ready", 64'(eoi_ready), 64'd1);
    check("rstmid_irq_valid", 64'(irq_valid), 64'd0);
    check("rstmid_irq_id", 64'(irq_id), 64'd0);
    check("rstmid_pending", 64'(pending), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Randomized edge bursts against a set-based model: presented in ascending order
    // among enabled channels, masked ones stay pending until enabled.
    for (int round = 0; round < 25; round++) begin
      r_set = 16'($urandom_range(1, 16'hFFFF));
      m_set = 16'($urandom);
      served = r_set & m_set;
      held   = r_set & ~m_set;
      cfg_mask = m_set;
      cnt = 0;
      for (int i = 0; i < N; i++) if (served[i]) begin exp_irq.push_back(i); cnt++; end
      acc_cnt = 0;
      irq_pad_in = r_set;
      @(posedge clk); #1;
      irq_pad_in = '0;
      repeat (SYNC + 2) @(posedge clk);
      #1;
      wait_accepts(cnt);
      repeat (3) @(posedge clk);
      #1;
      check("rnd_masked_pending", 64'(pending), 64'(held));
      check("rnd_idle", 64'(irq_valid), 64'd0);

      ids.delete();
      for (int i = 0; i < N; i++) if (served[i]) ids.push_back(i);
      for (int k = 0; k < ids.size(); k++) begin
        a = $urandom_range(0, ids.size() - 1);
        b = $urandom_range(0, ids.size() - 1);
        tmp = ids[a]; ids[a] = ids[b]; ids[b] = tmp;
      end
      bogus = $urandom_range(0, N - 1);
      if (!served[bogus]) eoi_issue(bogus, 0);
      foreach (ids[k]) eoi_issue(ids[k], 1);

      cfg_mask = '1;
      cnt = 0;
      for (int i = 0; i < N; i++) if (held[i]) begin exp_irq.push_back(i); cnt++; end
      acc_cnt = 0;
      wait_accepts(cnt);
      for (int i = 0; i < N; i++) if (held[i]) eoi_issue(i, 1);
      repeat (PULSE + 4) @(posedge clk);
      #1;
      check("rnd_final_pending", 64'(pending), 64'd0);
      check("rnd_irq_drained", 64'(exp_irq.size()), 64'd0);
      check("rnd_eoi_drained", 64'(exp_eoi.size()), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
